// File: rtl/spi_master_reader_pkg.sv
// Shared SPI reader types: FSM state encoding, default half-period divider and counter widths.
// Imported by the reader top and its half-period tick generator.
package spi_master_reader_pkg;

  localparam int HALF_DIV_DEFAULT = 8;
  localparam int DIV_W            = 8;
  localparam int BIT_W            = 3;
  localparam int BYTE_W           = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } state_t;

endpackage

// File: rtl/spi_master_reader_clk_div.sv
// Half-period tick generator: tick fires on the HALF_DIV-th enabled cycle, then the count restarts.
// Zero latency from count to tick; clr has priority and holds the count at zero.
module spi_clk_div
  import spi_master_reader_pkg::*;
#(
  parameter int HALF_DIV = HALF_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [DIV_W-1:0] LAST = DIV_W'(HALF_DIV - 1);

  logic [DIV_W-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master_reader.sv
// Mode-0 SPI register reader: sends an 8-bit address, then clocks in len data bytes MSB first.
// Start is accepted only in IDLE (no queuing); done and busy-low share the last GAP cycle.
module spi_master_reader
  import spi_master_reader_pkg::*;
#(
  parameter int HALF_DIV = HALF_DIV_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  addr,
  input  logic [3:0]  len,
  output logic        busy,
  output logic [7:0]  rdata,
  output logic        rdata_valid,
  output logic        done,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        spi_ss
);

  state_t            state, state_nx;
  logic [7:0]        addr_q, addr_nx;
  logic [BYTE_W-1:0] byte_cnt, byte_nx;
  logic [BIT_W-1:0]  bit_cnt, bit_nx;
  logic              addr_phase, addr_phase_nx;
  logic [7:0]        shreg, shreg_nx;
  logic [7:0]        rdata_q, rdata_nx;
  logic              rv_q, rv_nx;
  logic              sck_q, sck_nx;
  logic              mosi_q, mosi_nx;
  logic              ss_q, ss_nx;
  logic              miso_meta, miso_sync;
  logic              tick;
  logic              last_byte;

  spi_clk_div #(.HALF_DIV(HALF_DIV)) u_clk_div (
    .clk  (clk),
    .rst  (rst),
    .en   (state != ST_IDLE),
    .clr  (state == ST_IDLE),
    .tick (tick)
  );

  // The address byte ends the transfer when len is zero; otherwise the final data byte does.
  assign last_byte = addr_phase ? (byte_cnt == '0) : (byte_cnt == BYTE_W'(1));

  always_comb begin
    state_nx      = state;
    addr_nx       = addr_q;
    byte_nx       = byte_cnt;
    bit_nx        = bit_cnt;
    addr_phase_nx = addr_phase;
    shreg_nx      = shreg;
    rdata_nx      = rdata_q;
    rv_nx         = 1'b0;
    sck_nx        = sck_q;
    mosi_nx       = mosi_q;
    ss_nx         = ss_q;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nx      = ST_SETUP;
          addr_nx       = addr;
          byte_nx       = len;
          bit_nx        = 3'd7;
          addr_phase_nx = 1'b1;
          ss_nx         = 1'b0;
          mosi_nx       = addr[7];
        end
      end
      ST_SETUP: begin
        if (tick) begin
          state_nx = ST_SHIFT;
          sck_nx   = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (tick && sck_q) begin
          // Falling edge: capture MISO and present the next address bit.
          sck_nx   = 1'b0;
          shreg_nx = {shreg[6:0], miso_sync};
          mosi_nx  = (addr_phase && bit_cnt != '0) ? addr_q[bit_cnt - 3'd1] : 1'b0;
          if (!addr_phase && bit_cnt == '0) begin
            rdata_nx = {shreg[6:0], miso_sync};
            rv_nx    = 1'b1;
          end
        end else if (tick) begin
          bit_nx = bit_cnt - 3'd1;
          sck_nx = 1'b1;
          if (bit_cnt == '0) begin
            addr_phase_nx = 1'b0;
            if (!addr_phase) begin
              byte_nx = byte_cnt - 1'b1;
            end
            if (last_byte) begin
              state_nx = ST_HOLD;
              sck_nx   = 1'b0;
            end
          end
        end
      end
      ST_HOLD: begin
        if (tick) begin
          state_nx = ST_GAP;
          ss_nx    = 1'b1;
        end
      end
      ST_GAP: begin
        if (tick) begin
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      addr_q     <= '0;
      byte_cnt   <= '0;
      bit_cnt    <= '0;
      addr_phase <= 1'b0;
      shreg      <= '0;
      rdata_q    <= '0;
      rv_q       <= 1'b0;
      sck_q      <= 1'b0;
      mosi_q     <= 1'b0;
      ss_q       <= 1'b1;
      miso_meta  <= 1'b0;
      miso_sync  <= 1'b0;
    end else begin
      state      <= state_nx;
      addr_q     <= addr_nx;
      byte_cnt   <= byte_nx;
      bit_cnt    <= bit_nx;
      addr_phase <= addr_phase_nx;
      shreg      <= shreg_nx;
      rdata_q    <= rdata_nx;
      rv_q       <= rv_nx;
      sck_q      <= sck_nx;
      mosi_q     <= mosi_nx;
      ss_q       <= ss_nx;
      miso_meta  <= spi_miso;
      miso_sync  <= miso_meta;
    end
  end

  assign done        = (state == ST_GAP) && tick;
  assign busy        = (state != ST_IDLE) && !done;
  assign rdata       = rdata_q;
  assign rdata_valid = rv_q;
  assign spi_sck     = sck_q;
  assign spi_mosi    = mosi_q;
  assign spi_ss      = ss_q;

endmodule

// File: tb/tb_spi_master_reader.sv
// Bench for spi_master_reader: two instances (HALF_DIV 8 and 6) share one behavioural slave
// whose register file reads back reg[a] = a ^ 8'hA5 with auto-incrementing address.
module tb_spi_master_reader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start8 = 1'b0;
  logic       start6 = 1'b0;
  logic [7:0] addr = 8'h00;
  logic [3:0] len = 4'h0;
  logic       miso = 1'b0;
  logic       sel = 1'b0;

  logic       busy8, rv8, done8, sck8, mosi8, ss8;
  logic       busy6, rv6, done6, sck6, mosi6, ss6;
  logic [7:0] rdata8, rdata6;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  spi_master_reader u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .addr(addr), .len(len),
    .busy(busy8), .rdata(rdata8), .rdata_valid(rv8), .done(done8),
    .spi_sck(sck8), .spi_mosi(mosi8), .spi_miso(miso), .spi_ss(ss8)
  );

  spi_master_reader #(.HALF_DIV(6)) u_dut6 (
    .clk(clk), .rst(rst), .start(start6), .addr(addr), .len(len),
    .busy(busy6), .rdata(rdata6), .rdata_valid(rv6), .done(done6),
    .spi_sck(sck6), .spi_mosi(mosi6), .spi_miso(miso), .spi_ss(ss6)
  );

  logic       sck_m, ss_m, mosi_m, busy_m, rv_m, done_m;
  logic [7:0] rdata_m;
  assign sck_m   = sel ? sck6   : sck8;
  assign ss_m    = sel ? ss6    : ss8;
  assign mosi_m  = sel ? mosi6  : mosi8;
  assign busy_m  = sel ? busy6  : busy8;
  assign rv_m    = sel ? rv6    : rv8;
  assign done_m  = sel ? done6  : done8;
  assign rdata_m = sel ? rdata6 : rdata8;

  // Slave: counts SCK rising edges per select, captures the address, shifts data out on falling SCK.
  int         edges = 0;
  logic [7:0] sl_addr = 8'h00;
  int         sl_k;
  logic [7:0] sl_d;

  always @(posedge sck_m or negedge ss_m) begin
    if (sck_m) begin
      if (!ss_m) begin
        edges = edges + 1;
        if (edges <= 8) sl_addr = {sl_addr[6:0], mosi_m};
      end
    end else begin
      edges = 0;
    end
  end

  always @(negedge sck_m) begin
    if (!ss_m && edges >= 8) begin
      sl_k = edges - 8;
      sl_d = (sl_addr + 8'(sl_k / 8)) ^ 8'hA5;
      miso = sl_d[7 - (sl_k % 8)];
    end
  end

  logic [7:0] cap_bytes [16];
  int         cap_n;
  bit         busy_gap, busy_at_done, post_busy;

  task automatic run_txn(input logic use6, input logic [7:0] a, input logic [3:0] l,
                         input bit extra_start, output int cyc, output int n_done,
                         output bit timed_out);
    bit fin;
    sel = use6; addr = a; len = l;
    cap_n = 0; n_done = 0; timed_out = 0; fin = 0;
    busy_gap = 0; busy_at_done = 1; post_busy = 0;
    @(negedge clk);
    if (use6) start6 = 1'b1; else start8 = 1'b1;
    cyc = 1;
    for (int i = 0; i < 3000 && !fin; i++) begin
      @(negedge clk);
      start6 = 1'b0; start8 = 1'b0;
      cyc++;
      if (extra_start && cyc == 40) begin
        if (use6) start6 = 1'b1; else start8 = 1'b1;
      end
      if (rv_m && cap_n < 16) begin
        cap_bytes[cap_n] = rdata_m;
        cap_n++;
      end
      if (done_m) begin
        n_done++;
        busy_at_done = busy_m;
        fin = 1;
        if (extra_start) begin
          if (use6) start6 = 1'b1; else start8 = 1'b1;
        end
      end else if (!busy_m) begin
        busy_gap = 1;
      end
    end
    if (!fin) timed_out = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      start6 = 1'b0; start8 = 1'b0;
      if (done_m) n_done++;
      if (busy_m || !ss_m) post_busy = 1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({ss8, sck8, mosi8, busy8, rv8, done8, rdata8} !== {6'b100000, 8'h00}) begin
      failures++;
      $display("FAIL reset_dut8 got ss,sck,mosi,busy,rv,done,rdata=%b expected 10000000000000",
               {ss8, sck8, mosi8, busy8, rv8, done8, rdata8});
    end
    checks++;
    if ({ss6, sck6, mosi6, busy6, rv6, done6, rdata6} !== {6'b100000, 8'h00}) begin
      failures++;
      $display("FAIL reset_dut6 got ss,sck,mosi,busy,rv,done,rdata=%b expected 10000000000000",
               {ss6, sck6, mosi6, busy6, rv6, done6, rdata6});
    end
    rst = 1'b0;
  endtask

  task automatic test_read_one();
    int cyc, nd; bit to;
    run_txn(1'b0, 8'h10, 4'd1, 1'b0, cyc, nd, to);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL read_one_timeout got %0b expected 0", to); end
    checks++; if (nd !== 1) begin failures++; $display("FAIL read_one_done_count got %0d expected 1", nd); end
    checks++; if (cap_n !== 1) begin failures++; $display("FAIL read_one_valid_count got %0d expected 1", cap_n); end
    checks++; if (cap_bytes[0] !== 8'hB5) begin failures++; $display("FAIL read_one_rdata got %h expected b5", cap_bytes[0]); end
    checks++; if (edges !== 16) begin failures++; $display("FAIL read_one_edges got %0d expected 16", edges); end
    checks++; if (sl_addr !== 8'h10) begin failures++; $display("FAIL read_one_mosi_addr got %h expected 10", sl_addr); end
    checks++; if (cyc !== 281) begin failures++; $display("FAIL read_one_cycles got %0d expected 281", cyc); end
    checks++; if (busy_gap !== 1'b0) begin failures++; $display("FAIL read_one_busy_gap got %0b expected 0", busy_gap); end
    checks++; if (busy_at_done !== 1'b0) begin failures++; $display("FAIL read_one_busy_at_done got %0b expected 0", busy_at_done); end
  endtask

  task automatic test_wrap();
    int cyc, nd; bit to;
    run_txn(1'b0, 8'hFE, 4'd3, 1'b0, cyc, nd, to);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL wrap_timeout got %0b expected 0", to); end
    checks++; if (cap_n !== 3) begin failures++; $display("FAIL wrap_valid_count got %0d expected 3", cap_n); end
    checks++;
    if ({cap_bytes[0], cap_bytes[1], cap_bytes[2]} !== 24'h5B5AA5) begin
      failures++;
      $display("FAIL wrap_rdata got %h %h %h expected 5b 5a a5", cap_bytes[0], cap_bytes[1], cap_bytes[2]);
    end
    checks++; if (edges !== 32) begin failures++; $display("FAIL wrap_edges got %0d expected 32", edges); end
    checks++; if (cyc !== 537) begin failures++; $display("FAIL wrap_cycles got %0d expected 537", cyc); end
  endtask

  task automatic test_addr_only();
    int cyc, nd; bit to;
    run_txn(1'b0, 8'h33, 4'd0, 1'b0, cyc, nd, to);
    checks++; if (edges !== 8) begin failures++; $display("FAIL addr_only_edges got %0d expected 8", edges); end
    checks++; if (sl_addr !== 8'b00110011) begin failures++; $display("FAIL addr_only_mosi got %b expected 00110011", sl_addr); end
    checks++; if (cap_n !== 0) begin failures++; $display("FAIL addr_only_valid_count got %0d expected 0", cap_n); end
    checks++; if (nd !== 1) begin failures++; $display("FAIL addr_only_done_count got %0d expected 1", nd); end
    checks++; if (cyc !== 153) begin failures++; $display("FAIL addr_only_cycles got %0d expected 153", cyc); end
  endtask

  task automatic test_ignore_start();
    int cyc, nd; bit to;
    run_txn(1'b0, 8'h10, 4'd1, 1'b1, cyc, nd, to);
    checks++; if (nd !== 1) begin failures++; $display("FAIL ignore_done_count got %0d expected 1", nd); end
    checks++; if (edges !== 16) begin failures++; $display("FAIL ignore_edges got %0d expected 16", edges); end
    checks++; if (cyc !== 281) begin failures++; $display("FAIL ignore_cycles got %0d expected 281", cyc); end
    checks++; if (post_busy !== 1'b0) begin failures++; $display("FAIL ignore_restart got %0b expected 0", post_busy); end
    checks++; if (cap_bytes[0] !== 8'hB5) begin failures++; $display("FAIL ignore_rdata got %h expected b5", cap_bytes[0]); end
  endtask

  task automatic test_reset_mid();
    int cyc, nd, ndone; bit to, hit;
    sel = 1'b0; addr = 8'h10; len = 4'd1; hit = 0; ndone = 0;
    @(negedge clk); start8 = 1'b1;
    for (int i = 0; i < 2000 && !hit; i++) begin
      @(negedge clk); start8 = 1'b0;
      if (edges == 12) hit = 1;
    end
    checks++; if (hit !== 1'b1) begin failures++; $display("FAIL rst_mid_reach_bit got %0b expected 1", hit); end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({ss8, sck8} !== 2'b10) begin
      failures++;
      $display("FAIL rst_mid_outputs got ss,sck=%b expected 10", {ss8, sck8});
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done8) ndone++;
    end
    checks++; if (ndone !== 0) begin failures++; $display("FAIL rst_mid_no_done got %0d expected 0", ndone); end
    rst = 1'b0;
    run_txn(1'b0, 8'h01, 4'd1, 1'b0, cyc, nd, to);
    checks++; if (cap_n !== 1 || cap_bytes[0] !== 8'hA4) begin failures++; $display("FAIL rst_mid_followup got n=%0d rdata=%h expected n=1 rdata=a4", cap_n, cap_bytes[0]); end
    checks++; if (nd !== 1) begin failures++; $display("FAIL rst_mid_followup_done got %0d expected 1", nd); end
  endtask

  task automatic test_div6();
    int cyc, nd; bit to;
    run_txn(1'b1, 8'h10, 4'd1, 1'b0, cyc, nd, to);
    checks++; if (cap_n !== 1 || cap_bytes[0] !== 8'hB5) begin failures++; $display("FAIL div6_rdata got n=%0d rdata=%h expected n=1 rdata=b5", cap_n, cap_bytes[0]); end
    checks++; if (edges !== 16) begin failures++; $display("FAIL div6_edges got %0d expected 16", edges); end
    checks++; if (cyc !== 211) begin failures++; $display("FAIL div6_cycles got %0d expected 211", cyc); end
    checks++; if (nd !== 1) begin failures++; $display("FAIL div6_done_count got %0d expected 1", nd); end
  endtask

  initial begin
    test_reset();
    test_read_one();
    test_wrap();
    test_addr_only();
    test_ignore_start();
    test_reset_mid();
    test_div6();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
